// File: rtl/johnson_phase_dec_pkg.sv
// Shared types and Johnson-code helpers for the phase decoder.
package johnson_pkg;

    typedef enum logic {SEARCH, LOCKED} jpd_state_t;

    // Widest Johnson code the helpers can evaluate; callers zero-extend.
    localparam int unsigned JC_MAXW = 32;

    typedef logic [JC_MAXW-1:0] jc_code_t;

    // A legal Johnson code has at most one 0/1 boundary across its n bits:
    // ones packed at the MSB end, ones packed at the LSB end, or uniform.
    function automatic logic jc_legal(input jc_code_t code, input int unsigned n);
        int unsigned edges;
        jc_code_t    sh;
        edges = 0;
        for (int unsigned i = 0; i < JC_MAXW - 1; i++) begin
            if (i + 1 < n) begin
                sh = code >> i;
                if (sh[0] != sh[1]) edges++;
            end
        end
        return (edges <= 1);
    endfunction

    // Phase index of a legal code: popcount when the MSB is set, otherwise
    // 2n - popcount, with all-zeros mapping to phase 0.
    function automatic int unsigned jc_idx(input jc_code_t code, input int unsigned n);
        int unsigned ones;
        jc_code_t    sh;
        ones = 0;
        for (int unsigned i = 0; i < JC_MAXW; i++) begin
            if (i < n) begin
                sh   = code >> i;
                ones += {31'b0, sh[0]};
            end
        end
        sh = code >> (n - 1);
        if (sh[0])          return ones;
        else if (ones == 0) return 0;
        else                return 2 * n - ones;
    endfunction

endpackage

// File: rtl/johnson_phase_dec_if.sv
// Upstream code input and decoded phase outputs of the Johnson phase decoder.
interface johnson_phase_dec_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = $clog2(2 * N);

    logic [N-1:0]   tr_cntr;
    logic           clr_err;
    logic [2*N-1:0] phase_oh;
    logic [IW-1:0]  phase_idx;
    logic           locked;
    logic           wrap;
    logic           err_pulse;
    logic [7:0]     err_cnt;

    modport master (
        output tr_cntr, clr_err,
        input  phase_oh, phase_idx, locked, wrap, err_pulse, err_cnt
    );

    modport slave (
        input  tr_cntr, clr_err,
        output phase_oh, phase_idx, locked, wrap, err_pulse, err_cnt
    );

endinterface

// File: rtl/johnson_phase_dec_decode.sv
// Combinational Johnson code classifier: legality flag and phase index.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  code,
    output logic          legal,
    output logic [IW-1:0] idx
);

    jc_code_t wide;

    // Zero-extend the code and evaluate the shared helpers.
    always_comb begin
        wide         = '0;
        wide[N-1:0]  = code;
        legal        = jc_legal(wide, N);
        idx          = IW'(jc_idx(wide, N));
    end

endmodule

// File: rtl/johnson_phase_dec.sv
// Checks a Johnson counter's sequence, locks after LOCK_CNT good steps and
// emits a registered one-hot phase, phase index, wrap marker and error stats.
module johnson_phase_dec
    import johnson_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 3
) (
    input  logic                clk,
    input  logic                rst,
    johnson_phase_dec_if.slave  bus
);

    localparam int unsigned  P        = 2 * N;
    localparam int unsigned  IW       = $clog2(P);
    localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);
    localparam logic [3:0]   LOCK_TGT = 4'(LOCK_CNT);

    logic          dec_legal;
    logic [IW-1:0] dec_idx;

    logic          cur_legal, prv_legal;
    logic [IW-1:0] cur_idx, prv_idx;
    logic [IW-1:0] prv_succ;
    logic          step_ok;

    jpd_state_t    state, state_next;
    logic [3:0]    ok_cnt, ok_cnt_next;
    logic          err_event;

    logic [P-1:0]  oh_q;
    logic [IW-1:0] idx_q;
    logic          locked_q;
    logic          wrap_q;
    logic          err_pulse_q;
    logic [7:0]    err_cnt_q;

    johnson_decode #(.N(N)) u_decode (
        .code  (bus.tr_cntr),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // S1 pipeline: current decoded sample and the one before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_legal <= 1'b0;
            prv_legal <= 1'b0;
            cur_idx   <= '0;
            prv_idx   <= '0;
        end else begin
            cur_legal <= dec_legal;
            cur_idx   <= dec_idx;
            prv_legal <= cur_legal;
            prv_idx   <= cur_idx;
        end
    end

    // Successor check with wrap from the last phase back to phase 0.
    always_comb begin
        prv_succ = (prv_idx == LAST_IDX) ? '0 : prv_idx + IW'(1);
        step_ok  = cur_legal & prv_legal & (cur_idx == prv_succ);
    end

    // Lock state register and good-step run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SEARCH;
            ok_cnt <= '0;
        end else begin
            state  <= state_next;
            ok_cnt <= ok_cnt_next;
        end
    end

    // Next-state logic: count good steps while searching, drop lock on a bad step.
    always_comb begin
        state_next  = state;
        ok_cnt_next = ok_cnt;
        err_event   = 1'b0;
        unique case (state)
            SEARCH: begin
                ok_cnt_next = step_ok ? ok_cnt + 4'd1 : '0;
                if (step_ok && (ok_cnt_next == LOCK_TGT)) state_next = LOCKED;
            end
            LOCKED: begin
                if (!step_ok) begin
                    state_next  = SEARCH;
                    ok_cnt_next = '0;
                    err_event   = 1'b1;
                end
            end
            default: begin
                state_next  = SEARCH;
                ok_cnt_next = '0;
            end
        endcase
    end

    // Registered phase outputs driven from the next state and the current index.
    always_ff @(posedge clk) begin
        if (rst) begin
            oh_q        <= '0;
            idx_q       <= '0;
            locked_q    <= 1'b0;
            wrap_q      <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_event;
            if (state_next == LOCKED) begin
                oh_q     <= P'(1) << cur_idx;
                idx_q    <= cur_idx;
                locked_q <= 1'b1;
                wrap_q   <= (cur_idx == '0);
            end else begin
                oh_q     <= '0;
                idx_q    <= '0;
                locked_q <= 1'b0;
                wrap_q   <= 1'b0;
            end
        end
    end

    // Saturating lock-loss counter; a clear coinciding with an error leaves 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (bus.clr_err) begin
            err_cnt_q <= err_event ? 8'd1 : 8'd0;
        end else if (err_event && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.phase_oh  = oh_q;
    assign bus.phase_idx = idx_q;
    assign bus.locked    = locked_q;
    assign bus.wrap      = wrap_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_johnson_phase_dec.sv
// Self-checking bench for johnson_phase_dec (N=4, LOCK_CNT=3).
module tb_johnson_phase_dec;

    localparam int N = 4;
    localparam int L = 3;
    localparam int P = 2 * N;

    logic clk = 1'b0;
    logic rst;

    johnson_phase_dec_if #(.N(N)) bus ();

    johnson_phase_dec #(.N(N), .LOCK_CNT(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference: the upstream Johnson sequence, generated by shifting.
    logic [N-1:0] jtab [P];
    int           up_idx;

    // Reference model state: last two sample indices (-1 = illegal).
    int  hist [$];
    int  run;
    bit  m_locked;
    int  m_idx;
    bit  m_errp;
    int  m_errcnt;

    typedef struct {
        logic [N-1:0] code;
        logic         rst;
        logic         lk;
        int           idx;
        logic [P-1:0] oh;
        logic         wr;
        logic         ep;
        int           ec;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic int lookup(input logic [N-1:0] c);
        for (int k = 0; k < P; k++)
            if (jtab[k] == c) return k;
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] code, input logic clr, input logic r);
        bit ok;
        bit err;
        int a;
        int b;
        bus.tr_cntr = code;
        bus.clr_err = clr;
        rst         = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            hist.delete();
            run      = 0;
            m_locked = 0;
            m_idx    = 0;
            m_errp   = 0;
            m_errcnt = 0;
        end else begin
            ok = 0;
            if (hist.size() >= 2) begin
                a  = hist[hist.size() - 1];
                b  = hist[hist.size() - 2];
                ok = (a >= 0) && (b >= 0) && (a == (b + 1) % P);
            end
            err      = !ok && m_locked;
            run      = ok ? ((run < 1000) ? run + 1 : run) : 0;
            m_locked = (run >= L);
            m_idx    = m_locked ? hist[hist.size() - 1] : 0;
            m_errp   = err;
            if (clr)                          m_errcnt = err ? 1 : 0;
            else if (err && m_errcnt < 255)   m_errcnt++;
            hist.push_back(lookup(code));
            if (hist.size() > 2) void'(hist.pop_front());
        end
        #1;
        check("locked",    int'(bus.locked),    int'(m_locked));
        check("phase_idx", int'(bus.phase_idx), m_idx);
        check("phase_oh",  int'(bus.phase_oh),  m_locked ? (1 << m_idx) : 0);
        check("wrap",      int'(bus.wrap),      int'(m_locked && m_idx == 0));
        check("err_pulse", int'(bus.err_pulse), int'(m_errp));
        check("err_cnt",   int'(bus.err_cnt),   m_errcnt);
    endtask

    task automatic good();
        step(jtab[up_idx], 1'b0, 1'b0);
        up_idx = (up_idx + 1) % P;
    endtask

    task automatic bad();
        step(4'b1010, 1'b0, 1'b0);
        up_idx = (up_idx + 1) % P;
    endtask

    initial begin
        logic [N-1:0] c;
        int           pulses;
        int           ec0;
        int           r;

        c = '0;
        for (int k = 0; k < P; k++) begin
            jtab[k] = c;
            c = {~c[0], c[N-1:1]};
        end
        run = 0; m_locked = 0; m_idx = 0; m_errp = 0; m_errcnt = 0;

        // Lock from reset, wrap, then a single illegal code and relock.
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
        tbl[2]  = '{4'b1000, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
        tbl[3]  = '{4'b1100, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
        tbl[4]  = '{4'b1110, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
        tbl[5]  = '{4'b1111, 1'b0, 1'b1, 3, 8'h08, 1'b0, 1'b0, 0};
        tbl[6]  = '{4'b0111, 1'b0, 1'b1, 4, 8'h10, 1'b0, 1'b0, 0};
        tbl[7]  = '{4'b0011, 1'b0, 1'b1, 5, 8'h20, 1'b0, 1'b0, 0};
        tbl[8]  = '{4'b0001, 1'b0, 1'b1, 6, 8'h40, 1'b0, 1'b0, 0};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 7, 8'h80, 1'b0, 1'b0, 0};
        tbl[10] = '{4'b1000, 1'b0, 1'b1, 0, 8'h01, 1'b1, 1'b0, 0};
        tbl[11] = '{4'b1100, 1'b0, 1'b1, 1, 8'h02, 1'b0, 1'b0, 0};
        tbl[12] = '{4'b1010, 1'b0, 1'b1, 2, 8'h04, 1'b0, 1'b0, 0};
        tbl[13] = '{4'b1111, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1};
        tbl[14] = '{4'b0111, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1};
        tbl[15] = '{4'b0011, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1};
        tbl[16] = '{4'b0001, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1};
        tbl[17] = '{4'b0000, 1'b0, 1'b1, 7, 8'h80, 1'b0, 1'b0, 1};
        tbl[18] = '{4'b1000, 1'b0, 1'b1, 0, 8'h01, 1'b1, 1'b0, 1};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].code, 1'b0, tbl[i].rst);
            check("tbl_locked",    int'(bus.locked),    int'(tbl[i].lk));
            check("tbl_phase_idx", int'(bus.phase_idx), tbl[i].idx);
            check("tbl_phase_oh",  int'(bus.phase_oh),  int'(tbl[i].oh));
            check("tbl_wrap",      int'(bus.wrap),      int'(tbl[i].wr));
            check("tbl_err_pulse", int'(bus.err_pulse), int'(tbl[i].ep));
            check("tbl_err_cnt",   int'(bus.err_cnt),   tbl[i].ec);
        end
        up_idx = 2;

        // Legal skip 1100 -> 1111 while locked.
        for (int i = 0; i < 12; i++) good();
        for (int i = 0; i < P && up_idx != 2; i++) good();
        good();
        up_idx = 4;
        ec0    = m_errcnt;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            good();
            pulses += int'(bus.err_pulse);
        end
        check("skip_pulses",  pulses, 1);
        check("skip_err_cnt", int'(bus.err_cnt), ec0 + 1);

        // Drive err_cnt to saturation, then one more error.
        for (int k = 0; k < 300 && m_errcnt < 255; k++) begin
            for (int i = 0; i < 8; i++) good();
            bad();
        end
        for (int i = 0; i < 8; i++) good();
        check("sat_reach", int'(bus.err_cnt), 255);
        bad();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            good();
            pulses += int'(bus.err_pulse);
        end
        check("sat_pulse", pulses, 1);
        check("sat_hold",  int'(bus.err_cnt), 255);

        // clr_err in the same cycle as a lock loss.
        bad();
        step(jtab[up_idx], 1'b1, 1'b0);
        up_idx = (up_idx + 1) % P;
        check("clr_coinc_pulse", int'(bus.err_pulse), 1);
        check("clr_coinc_cnt",   int'(bus.err_cnt),   1);

        // Reset while locked, then relock with the same timing as from power-up.
        for (int i = 0; i < 8; i++) good();
        step(jtab[up_idx], 1'b0, 1'b1);
        up_idx = 0;
        check("rst_locked",  int'(bus.locked),    0);
        check("rst_oh",      int'(bus.phase_oh),  0);
        check("rst_idx",     int'(bus.phase_idx), 0);
        check("rst_err_cnt", int'(bus.err_cnt),   0);
        for (int i = 0; i < 6; i++) begin
            good();
            check("relock_locked", int'(bus.locked),    int'(i >= 4));
            check("relock_idx",    int'(bus.phase_idx), (i >= 4) ? i - 1 : 0);
        end

        // Constant illegal code: never locks, never errors.
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            step(4'b0101, 1'b0, 1'b0);
            check("hold_locked",    int'(bus.locked),    0);
            check("hold_err_pulse", int'(bus.err_pulse), 0);
            check("hold_err_cnt",   int'(bus.err_cnt),   0);
        end

        // Randomized mix of good steps, bad codes, skips, clears and resets.
        step(4'b0000, 1'b0, 1'b1);
        up_idx = 0;
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                step(N'($urandom_range(0, 15)), 1'b0, 1'b0);
                up_idx = (up_idx + 1) % P;
            end else if (r < 6) begin
                up_idx = (up_idx + 1 + int'($urandom_range(1, P - 2))) % P;
                good();
            end else if (r < 8) begin
                step(jtab[up_idx], 1'b1, 1'b0);
                up_idx = (up_idx + 1) % P;
            end else if (r == 99) begin
                step(jtab[up_idx], 1'b0, 1'b1);
                up_idx = 0;
            end else begin
                good();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/johnson_phase_dec.md
# johnson_phase_dec

Downstream consumer of the twisted-ring (Johnson) counter. It samples the N-bit Johnson code each cycle, checks that the code is legal and that each step is the correct successor, and locks after a run of good steps. While locked it outputs a registered one-hot phase (2N wide), a binary phase index and a wrap marker. It also flags and counts sequence errors, giving downstream phase-sequenced logic a clean, checked timebase.

## Interface
- N, 4: Johnson counter width; 2N phases.
- LOCK_CNT, 3: consecutive good steps required to lock; range 1..15.
- IW, $clog2(2N): phase index width (derived, not overridable).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tr_cntr  in  N  Johnson code from the upstream counter, which advances every cycle.
- clr_err  in  1  synchronous clear of err_cnt.
- phase_oh  out  2N  registered one-hot phase; all zero when not locked.
- phase_idx  out  IW  registered phase index; 0 when not locked.
- locked  out  1  lock status.
- wrap  out  1  high with phase_idx==0 while locked (one per 2N cycles).
- err_pulse  out  1  one-cycle pulse on loss of lock.
- err_cnt  out  8  saturating count of lock losses.

## Operation
- Upstream sequence for N=4, listed as index:code: 0:0000, 1:1000, 2:1100, 3:1110, 4:1111, 5:0111, 6:0011, 7:0001, then back to 0.
- Legal code: either a run of ones from the MSB (1..10..0, including all-ones and all-zeros) or a run of ones from the LSB (0..01..1).
- Index mapping for legal codes:
  - MSB=1: index = popcount.
  - MSB=0 and code nonzero: index = 2N - popcount.
  - All zeros: index = 0.
- S1 registers: cur_idx, cur_legal, prv_idx, prv_legal; prv takes cur every cycle.
- step_ok = cur_legal & prv_legal & (cur_idx == (prv_idx+1) mod 2N). This is combinational from S1.
- FSM states:
  - SEARCH: ok_cnt increments on step_ok and clears to 0 otherwise. When ok_cnt reaches LOCK_CNT, go to LOCKED.
  - LOCKED: on !step_ok, go to SEARCH, clear ok_cnt, pulse err_pulse, and increment err_cnt. Otherwise stay.
- Illegal codes or skipped steps during SEARCH only reset ok_cnt; they never count as errors.
- Outputs are registered from the next state and cur_idx:
  - Next state LOCKED: phase_oh = 1<<cur_idx, phase_idx = cur_idx, wrap = (cur_idx==0).
  - Otherwise: phase_oh, phase_idx and wrap are 0.
- err_cnt saturates at 255.
- clr_err clears err_cnt. If clr_err coincides with an error, the result is 1 (clear, then count).

## Timing
- Reset values: phase_oh=0, phase_idx=0, locked=0, wrap=0, err_pulse=0, err_cnt=0, state SEARCH, ok_cnt=0, S1 legal flags=0.
- Latency: tr_cntr sampled in cycle t appears on phase_oh/phase_idx in cycle t+2.
- Lock from reset, with both blocks sharing rst (cycle 0 = first cycle with rst low):
  - First step_ok occurs in cycle 2.
  - locked=1 from cycle 1+LOCK_CNT+1, i.e. cycle 5 for LOCK_CNT=3, showing phase_idx=3.
- Error in LOCKED:
  - A bad sample in cycle t gives step_ok=0 in cycle t+1.
  - In cycle t+2: locked=0, phase_oh=0, err_pulse=1, err_cnt+1.
  - err_pulse is high for exactly one cycle.
- A single bad code breaks two steps (into it and out of it). Relock therefore needs LOCK_CNT good steps after the bad code leaves S1.
- Wrap-around: index 2N-1 followed by 0 is a good step; wrap asserts in that output cycle.
- rst mid-operation: all outputs are at reset values in the cycle after rst is sampled high; rst has priority over clr_err and all FSM events.

## Structure
- Package johnson_pkg contains:
  - typedef enum logic {SEARCH, LOCKED} jpd_state_t;
  - functions jc_legal(code) and jc_idx(code), parameterised via N passed as a function argument width or package parameter.
- Sub-module johnson_decode: purely combinational code → {legal, idx}. It is instantiated once at the S1 input.
- The top level holds the S1 registers, the FSM with ok_cnt, the error counter and the output registers.
- Target size is about 150–250 lines total.

## Test plan
- Shared reset, N=4, LOCK_CNT=3, bench drives the upstream counter model → locked rises in cycle 5 with phase_idx=3 and phase_oh=8'h08, then steps 1 per cycle; wrap is high every 8 cycles with phase_oh=8'h01.
- While locked, force tr_cntr=4'b1010 (illegal) for 1 cycle → err_pulse for exactly one cycle, err_cnt=1, locked=0, phase_oh=0; relock 3 good steps after recovery.
- While locked, inject a legal skip (1100 directly to 1111) → treated as an error, same response as the illegal-code case.
- Preload err_cnt to 255 via 255 forced errors, then force one more → err_cnt stays 255; clr_err coincident with an error → err_cnt=1.
- Assert rst for 1 cycle while locked → next cycle all outputs 0 and err_cnt=0; relock timing identical to the first scenario.
- Hold tr_cntr=4'b0101 constantly → never locks; err_pulse never asserts; err_cnt stays 0.
